// File: rtl/peribus_irqc_pkg.sv
// Shared types and register-map constants for the Peribus interrupt controller.
package peribus_irqc_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        REQUEST    = 2'd1,
        IN_SERVICE = 2'd2
    } irqc_state_e;

    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_MASK    = 2'd1;
    localparam logic [1:0] REG_ACTIVE  = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    localparam int CTRL_GIE_BIT = 0;

    // Vector width never drops below one bit, even for a single line.
    function automatic int vec_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irqc_priority_encoder.sv
// Lowest-index-first priority encoder: idx is the lowest set bit of req.
module irqc_priority_encoder
    import peribus_irqc_pkg::*;
#(
    parameter int NUM_LINES = 8,
    parameter int VEC_BITS  = vec_bits(NUM_LINES)
) (
    input  logic [NUM_LINES-1:0] req,
    output logic [VEC_BITS-1:0]  idx,
    output logic                 valid
);

    always_comb begin
        idx   = '0;
        valid = |req;
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            if (req[i]) idx = VEC_BITS'(i);
        end
    end

endmodule

// File: rtl/peribus_irq_controller.sv
// Edge-capturing, masked, vectored interrupt controller on a 4-word Peribus window.
// Define IRQC_NESTING_EN to let higher-priority lines preempt an in-service one.
module peribus_irq_controller
    import peribus_irqc_pkg::*;
#(
    parameter int NUM_LINES = 8,
    parameter int VEC_BITS  = vec_bits(NUM_LINES)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_LINES-1:0] irq_lines,
    input  logic [1:0]           addr,
    input  logic [15:0]          write_data,
    input  logic                 write_en,
    input  logic                 read_en,
    input  logic                 chipselect,
    output logic [15:0]          read_data,
    output logic                 cpu_irq,
    output logic [VEC_BITS-1:0]  cpu_vector,
    input  logic                 cpu_ack,
    input  logic                 cpu_eoi
);

    logic [NUM_LINES-1:0] irq_prev, pending, mask_q, active;
    logic                 gie;
    logic [VEC_BITS-1:0]  cur_vector, cur_nxt;
    irqc_state_e          state, state_nxt;

    logic                 wr_pend, wr_mask, wr_ctrl;
    logic [NUM_LINES-1:0] wr_bits, rise, w1c, pend_raw, pend_nxt, mask_nxt, act_nxt;
    logic [NUM_LINES-1:0] eligible, cur_bit;
    logic                 gie_nxt, cur_ok, cur_keep, ack_take;
    logic [VEC_BITS-1:0]  best_idx;
    logic                 best_vld;
    logic                 bus_unused;

    assign wr_pend = chipselect & write_en & (addr == REG_PENDING);
    assign wr_mask = chipselect & write_en & (addr == REG_MASK);
    assign wr_ctrl = chipselect & write_en & (addr == REG_CTRL);
    assign wr_bits = write_data[NUM_LINES-1:0];
    assign bus_unused = ^write_data;

    assign rise     = irq_lines & ~irq_prev;
    assign w1c      = wr_pend ? wr_bits : '0;
    assign pend_raw = (pending & ~w1c) | rise;
    assign mask_nxt = wr_mask ? wr_bits : mask_q;
    assign gie_nxt  = wr_ctrl ? write_data[CTRL_GIE_BIT] : gie;

    assign eligible = gie ? (pending & mask_q) : '0;
    assign cur_bit  = NUM_LINES'(1) << cur_vector;
    assign cur_ok   = gie & |(cur_bit & pending & mask_q);
    // Withdraw looks at post-write values so cpu_irq drops the cycle after the write.
    assign cur_keep = gie_nxt & |(cur_bit & pend_raw & mask_nxt);

    // A rise on the acked line in the same cycle keeps it pending.
    assign pend_nxt = (pending & ~w1c & ~(ack_take ? cur_bit : '0)) | rise;

    irqc_priority_encoder #(.NUM_LINES(NUM_LINES), .VEC_BITS(VEC_BITS)) u_best (
        .req   (eligible),
        .idx   (best_idx),
        .valid (best_vld)
    );

`ifdef IRQC_NESTING_EN
    logic [VEC_BITS-1:0]  act_idx, rest_idx;
    logic                 act_vld, rest_vld;
    logic [NUM_LINES-1:0] act_rest;

    irqc_priority_encoder #(.NUM_LINES(NUM_LINES), .VEC_BITS(VEC_BITS)) u_act (
        .req   (active),
        .idx   (act_idx),
        .valid (act_vld)
    );

    assign act_rest = active & ~(NUM_LINES'(1) << act_idx);

    irqc_priority_encoder #(.NUM_LINES(NUM_LINES), .VEC_BITS(VEC_BITS)) u_rest (
        .req   (act_rest),
        .idx   (rest_idx),
        .valid (rest_vld)
    );
`endif

    always_comb begin
        state_nxt = state;
        cur_nxt   = cur_vector;
        act_nxt   = active;
        ack_take  = 1'b0;
        case (state)
            IDLE: begin
                if (best_vld) begin
                    cur_nxt   = best_idx;
                    state_nxt = REQUEST;
                end
            end
            REQUEST: begin
                if (cpu_ack && cur_ok) begin
                    ack_take  = 1'b1;
                    act_nxt   = active | cur_bit;
                    state_nxt = IN_SERVICE;
                end else if (!cur_keep) begin
`ifdef IRQC_NESTING_EN
                    // A withdrawn preemption falls back to the interrupted service.
                    if (act_vld) begin
                        cur_nxt   = act_idx;
                        state_nxt = IN_SERVICE;
                    end else begin
                        state_nxt = IDLE;
                    end
`else
                    state_nxt = IDLE;
`endif
                end
            end
            IN_SERVICE: begin
`ifdef IRQC_NESTING_EN
                if (cpu_eoi) begin
                    act_nxt = act_rest;
                    if (rest_vld) begin
                        cur_nxt   = rest_idx;
                        state_nxt = IN_SERVICE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (best_vld && (!act_vld || best_idx < act_idx)) begin
                    cur_nxt   = best_idx;
                    state_nxt = REQUEST;
                end
`else
                if (cpu_eoi) begin
                    act_nxt   = active & ~cur_bit;
                    state_nxt = IDLE;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            irq_prev   <= '0;
            pending    <= '0;
            mask_q     <= '0;
            active     <= '0;
            gie        <= 1'b0;
            cur_vector <= '0;
            state      <= IDLE;
        end else begin
            irq_prev   <= irq_lines;
            pending    <= pend_nxt;
            mask_q     <= mask_nxt;
            active     <= act_nxt;
            gie        <= gie_nxt;
            cur_vector <= cur_nxt;
            state      <= state_nxt;
        end
    end

    always_comb begin
        read_data = '0;
        if (chipselect && read_en) begin
            case (addr)
                REG_PENDING: read_data[NUM_LINES-1:0] = pending;
                REG_MASK:    read_data[NUM_LINES-1:0] = mask_q;
                REG_ACTIVE:  read_data[NUM_LINES-1:0] = active;
                default: begin
                    read_data[CTRL_GIE_BIT] = gie;
                    read_data[15:8]         = 8'(cur_vector);
                end
            endcase
        end
    end

    assign cpu_irq    = (state == REQUEST);
    assign cpu_vector = cur_vector;

endmodule

// File: tb/tb_peribus_irq_controller.sv
// Directed and randomized bench for peribus_irq_controller against a behavioural model.
// Honours IRQC_NESTING_EN for the nesting scenario and the model.
module tb_peribus_irq_controller;

    localparam int N  = 8;
    localparam int VB = 3;
    localparam logic [15:0] LM = 16'h00FF;

    logic          clock, reset_n;
    logic [N-1:0]  irq_lines;
    logic [1:0]    addr;
    logic [15:0]   write_data, read_data;
    logic          write_en, read_en, chipselect;
    logic          cpu_irq, cpu_ack, cpu_eoi;
    logic [VB-1:0] cpu_vector;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: pending/mask/active as sets, state as 0=idle 1=request 2=service
    logic [15:0] m_prev, m_pend, m_mask, m_act;
    logic        m_gie;
    int          m_st, m_cur;

    peribus_irq_controller #(.NUM_LINES(N)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .irq_lines  (irq_lines),
        .addr       (addr),
        .write_data (write_data),
        .write_en   (write_en),
        .read_en    (read_en),
        .chipselect (chipselect),
        .read_data  (read_data),
        .cpu_irq    (cpu_irq),
        .cpu_vector (cpu_vector),
        .cpu_ack    (cpu_ack),
        .cpu_eoi    (cpu_eoi)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int lowest(input logic [15:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [15:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return m_pend;
            2'd1:    return m_mask;
            2'd2:    return m_act;
            default: return {8'(m_cur), 7'd0, m_gie};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_irq(input string tag, input logic exp_irq, input int exp_vec);
        chk({tag, "_irq"}, 16'(cpu_irq), 16'(exp_irq));
        if (exp_irq) chk({tag, "_vec"}, 16'(cpu_vector), 16'(exp_vec));
    endtask

    // Combinational read: expected constant and model value at the current state.
    task automatic rd(input logic [1:0] a, input logic [15:0] exp, input string tag);
        addr    = a;
        read_en = 1'b1;
        #1;
        chk(tag, read_data, exp);
        chk({tag, "_model"}, read_data, m_read(a));
        read_en = 1'b0;
    endtask

    // Advance one clock: step the model on the current inputs, then compare outputs.
    task automatic cyc();
        logic [15:0] rise, w1c, raw, nm, el, np, na;
        logic        ng, wr, cur_ok, keep;
        int          ns, nc, best, la, rest;
        if (!reset_n) begin
            np = 0; nm = 0; na = 0; ng = 0; ns = 0; nc = 0; rise = 0;
        end else begin
            wr   = chipselect && write_en;
            rise = 16'(irq_lines) & ~m_prev;
            w1c  = (wr && addr == 2'd0) ? (write_data & LM) : 16'h0;
            nm   = (wr && addr == 2'd1) ? (write_data & LM) : m_mask;
            ng   = (wr && addr == 2'd3) ? write_data[0] : m_gie;
            raw  = (m_pend & ~w1c) | rise;
            np   = raw;
            na   = m_act;
            ns   = m_st;
            nc   = m_cur;
            el   = m_gie ? (m_pend & m_mask) : 16'h0;
            best = lowest(el);
            la   = lowest(m_act);
            case (m_st)
                0: if (best >= 0) begin nc = best; ns = 1; end
                1: begin
                    cur_ok = m_pend[m_cur] && m_mask[m_cur] && m_gie;
                    keep   = raw[m_cur] && nm[m_cur] && ng;
                    if (cpu_ack && cur_ok) begin
                        np[m_cur] = rise[m_cur];
                        na[m_cur] = 1'b1;
                        ns = 2;
                    end else if (!keep) begin
`ifdef IRQC_NESTING_EN
                        if (la >= 0) begin ns = 2; nc = la; end
                        else ns = 0;
`else
                        ns = 0;
`endif
                    end
                end
                default: begin
`ifdef IRQC_NESTING_EN
                    if (cpu_eoi) begin
                        if (la >= 0) na[la] = 1'b0;
                        rest = lowest(na);
                        if (rest >= 0) begin ns = 2; nc = rest; end
                        else ns = 0;
                    end else if (best >= 0 && (la < 0 || best < la)) begin
                        nc = best; ns = 1;
                    end
`else
                    if (cpu_eoi) begin
                        na[m_cur] = 1'b0;
                        ns = 0;
                    end
`endif
                end
            endcase
        end
        @(posedge clock);
        m_prev = reset_n ? 16'(irq_lines) : 16'h0;
        m_pend = np; m_mask = nm; m_act = na; m_gie = ng; m_st = ns; m_cur = nc;
        #1;
        write_en = 1'b0;
        cpu_ack  = 1'b0;
        cpu_eoi  = 1'b0;
        read_en  = 1'b0;
        chk("model_irq", 16'(cpu_irq), 16'(m_st == 1));
        chk("model_vec", 16'(cpu_vector), 16'(m_cur));
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        chipselect = 1'b1;
        write_en   = 1'b1;
        addr       = a;
        write_data = d;
        cyc();
    endtask

    initial begin
        reset_n = 1'b0; irq_lines = '0; addr = '0; write_data = '0;
        write_en = 1'b0; read_en = 1'b0; chipselect = 1'b1;
        cpu_ack = 1'b0; cpu_eoi = 1'b0;
        m_prev = 0; m_pend = 0; m_mask = 0; m_act = 0; m_gie = 0; m_st = 0; m_cur = 0;

        // Reset state
        cyc(); cyc();
        rd(2'd0, 16'h0, "rst_pend"); rd(2'd1, 16'h0, "rst_mask"); rd(2'd2, 16'h0, "rst_act");
        cyc();
        rd(2'd3, 16'h0, "rst_ctrl");
        chk_irq("rst", 1'b0, 0);
        chk("rst_vec", 16'(cpu_vector), 16'h0);
        reset_n = 1'b1;

        // Basic request / ack / eoi on line 2
        wr(2'd1, 16'h0005);
        wr(2'd3, 16'h0001);
        irq_lines = 8'h04; cyc(); irq_lines = 8'h00;
        rd(2'd0, 16'h0004, "t1_pend");
        chk_irq("t1_early", 1'b0, 0);
        cyc();
        chk_irq("t1_req", 1'b1, 2);
        rd(2'd3, 16'h0201, "t1_ctrl");
        cpu_ack = 1'b1; cyc();
        rd(2'd0, 16'h0, "t1_pend_ack"); rd(2'd2, 16'h0004, "t1_act");
        chk_irq("t1_ack", 1'b0, 0);
        cpu_eoi = 1'b1; cyc();
        rd(2'd2, 16'h0, "t1_act_eoi");
        chk_irq("t1_eoi", 1'b0, 0);

        // Simultaneous lines 1 and 3: priority order
        wr(2'd1, 16'h00FF);
        irq_lines = 8'h0A; cyc(); irq_lines = 8'h00; cyc();
        chk_irq("t2_first", 1'b1, 1);
        cpu_ack = 1'b1; cyc();
        cpu_eoi = 1'b1; cyc();
        cyc();
        chk_irq("t2_second", 1'b1, 3);
        cpu_ack = 1'b1; cyc();
        cpu_eoi = 1'b1; cyc();

        // Masked line stays pending until unmasked
        wr(2'd1, 16'h0000);
        irq_lines = 8'h10; cyc(); irq_lines = 8'h00; cyc(); cyc();
        rd(2'd0, 16'h0010, "t3_pend");
        chk_irq("t3_masked", 1'b0, 0);
        wr(2'd1, 16'h0010);
        cyc();
        chk_irq("t3_unmask", 1'b1, 4);
        cpu_ack = 1'b1; cyc();
        cpu_eoi = 1'b1; cyc();

        // W1C withdraws the request; rise beats W1C on the same bit
        wr(2'd1, 16'h00FF);
        irq_lines = 8'h04; cyc(); irq_lines = 8'h00; cyc();
        chk_irq("t4_req", 1'b1, 2);
        wr(2'd0, 16'h0004);
        chk_irq("t4_withdraw", 1'b0, 0);
        rd(2'd0, 16'h0, "t4_pend_clr");
        irq_lines = 8'h04; chipselect = 1'b1; write_en = 1'b1; addr = 2'd0; write_data = 16'h0004;
        cyc(); irq_lines = 8'h00;
        rd(2'd0, 16'h0004, "t4_set_wins");
        cyc();
        chk_irq("t4_rereq", 1'b1, 2);
        cpu_ack = 1'b1; cyc();
        cpu_eoi = 1'b1; cyc();

        // Held-high line triggers once; reset during service clears everything
        irq_lines = 8'h01; cyc(); cyc();
        chk_irq("t5_req", 1'b1, 0);
        cpu_ack = 1'b1; cyc();
        rd(2'd0, 16'h0, "t5_pend_ack");
        cyc(); cyc();
        rd(2'd0, 16'h0, "t5_no_retrig"); rd(2'd2, 16'h0001, "t5_act");
        chk_irq("t5_svc", 1'b0, 0);
        reset_n = 1'b0; irq_lines = 8'h00; cyc();
        rd(2'd0, 16'h0, "t5_rst_pend"); rd(2'd1, 16'h0, "t5_rst_mask"); rd(2'd2, 16'h0, "t5_rst_act");
        chk_irq("t5_rst", 1'b0, 0);
        reset_n = 1'b1; cyc();
        rd(2'd3, 16'h0, "t5_rst_ctrl");

        // Line 0 arriving while line 5 is in service
        wr(2'd1, 16'h00FF);
        wr(2'd3, 16'h0001);
        irq_lines = 8'h20; cyc(); irq_lines = 8'h00; cyc();
        chk_irq("t6_req5", 1'b1, 5);
        cpu_ack = 1'b1; cyc();
        rd(2'd2, 16'h0020, "t6_act5");
        irq_lines = 8'h01; cyc(); irq_lines = 8'h00; cyc();
`ifdef IRQC_NESTING_EN
        chk_irq("t6_nest_req", 1'b1, 0);
        cpu_ack = 1'b1; cyc();
        rd(2'd2, 16'h0021, "t6_act_both");
        chk_irq("t6_nest_svc", 1'b0, 0);
        cpu_eoi = 1'b1; cyc();
        rd(2'd2, 16'h0020, "t6_act_back"); rd(2'd3, 16'h0501, "t6_ctrl_back");
        chk_irq("t6_back", 1'b0, 0);
        cpu_eoi = 1'b1; cyc();
        rd(2'd2, 16'h0, "t6_act_done");
        chk_irq("t6_done", 1'b0, 0);
`else
        chk_irq("t6_blocked", 1'b0, 0);
        rd(2'd0, 16'h0001, "t6_pend0"); rd(2'd2, 16'h0020, "t6_act_still5");
        cpu_eoi = 1'b1; cyc();
        rd(2'd2, 16'h0, "t6_act_eoi");
        cyc();
        chk_irq("t6_req0", 1'b1, 0);
        cpu_ack = 1'b1; cyc();
        cpu_eoi = 1'b1; cyc();
`endif

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            reset_n = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 3) == 0)
                irq_lines = irq_lines ^ (N'(1) << $urandom_range(0, N - 1));
            chipselect = ($urandom_range(0, 7) != 0);
            write_en   = ($urandom_range(0, 7) == 0);
            addr       = 2'($urandom_range(0, 3));
            write_data = 16'($urandom);
            if (addr == 2'd3 && $urandom_range(0, 3) != 0) write_data[0] = 1'b1;
            if (addr == 2'd1) write_data = write_data | 16'($urandom);
            cpu_ack = (m_st == 1) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
            cpu_eoi = (m_st == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            read_en = 1'b1;
            #1;
            chk("rand_read", read_data, chipselect ? m_read(addr) : 16'h0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
